// File: rtl/req_encoder_queue.sv
// req_encoder_queue
// -----------------------------------------------------------------------------
// Captures single-cycle request pulses on N lines into a pending register and
// hands one binary index at a time to a downstream consumer over valid/ready.
// Arbitration among eligible (pending & mask) bits is either fixed priority
// (lowest index wins, RR=0) or round-robin starting from a rotating pointer
// (RR=1).
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N-1:0] request pulses, bit k raises event k
//   mask     in   [N-1:0] 1 = bit eligible for selection (masked bits stay pending)
//   clr      in   synchronous flush of pending bits and output stage
//   idx      out  [W-1:0] encoded index being presented
//   valid    out  idx is valid
//   ready    in   consumer accepts idx when valid && ready
//   pending  out  [N-1:0] current pending register
//   drop     out  one-cycle pulse: a request hit an already-pending bit
// -----------------------------------------------------------------------------
module req_encoder_queue #(
    parameter int  N  = 8,
    parameter int  RR = 0,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         clr,
    output logic [W-1:0] idx,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         drop
);

    logic [N-1:0] r_pending;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_ptr;
    logic         r_drop;

    logic         w_load;
    logic         w_take;
    logic [N-1:0] w_elig;
    logic [N-1:0] w_hi_mask;
    logic [N-1:0] w_elig_hi;
    logic [N-1:0] w_clear;
    logic [W-1:0] w_sel;
    logic [W-1:0] w_ptr_next;

    // Index of the lowest set bit; 0 when nothing is set (caller gates on |v).
    function automatic logic [W-1:0] f_lowest(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = W'(k);
            end
        end
        return r;
    endfunction

    // The output stage can take a new index when empty or being drained.
    assign w_load = !r_valid || ready;
    assign w_elig = r_pending & mask;
    assign w_take = w_load && (|w_elig);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            localparam logic [W-1:0] BIT_IDX = W'(gi);
            // Bits at or above the round-robin pointer get first pick.
            assign w_hi_mask[gi] = (BIT_IDX >= r_ptr);
            // One-hot of the bit handed to the output stage this edge.
            assign w_clear[gi]   = w_take && (w_sel == BIT_IDX);
        end
    endgenerate

    assign w_elig_hi = w_elig & w_hi_mask;

    // Round-robin: search upward from ptr; if nothing lies at or above ptr,
    // the wrapped search is just the lowest eligible bit overall.
    assign w_sel = ((RR != 0) && (|w_elig_hi)) ? f_lowest(w_elig_hi)
                                               : f_lowest(w_elig);

    assign w_ptr_next = (w_sel == W'(N - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_drop    <= 1'b0;
        end else if (clr) begin
            // Flush wins over any request in the same cycle; idx simply holds.
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            r_drop    <= 1'b0;
        end else begin
            // A request on the bit being handed out re-pends it.
            r_pending <= (r_pending & ~w_clear) | req;
            r_drop    <= |(req & r_pending & ~w_clear);
            if (w_load) begin
                r_valid <= w_take;
                if (w_take) begin
                    r_idx <= w_sel;
                end
            end
            if (w_take && (RR != 0)) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign idx     = r_idx;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign drop    = r_drop;

endmodule

// File: tb/tb_req_encoder_queue.sv
// Bench for req_encoder_queue: three instances (N=8 fixed priority, N=8
// round-robin, N=5 round-robin) are compared every cycle against a
// behavioural model, with directed scenarios pinned by literal expectations
// followed by a randomized phase.
module tb_req_encoder_queue;

    logic clk;
    logic rst_n;

    logic [63:0] req_a  [3];
    logic [63:0] mask_a [3];
    logic        clr_a  [3];
    logic        ready_a[3];

    logic [2:0] idx0, idx1, idx2;
    logic       valid0, valid1, valid2;
    logic [7:0] pend0, pend1;
    logic [4:0] pend2;
    logic       drop0, drop1, drop2;

    logic        a_valid[3];
    logic [5:0]  a_idx  [3];
    logic [63:0] a_pend [3];
    logic        a_drop [3];

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 0;

    req_encoder_queue #(.N(8), .RR(0)) dut_fp8 (
        .clk(clk), .rst_n(rst_n), .req(req_a[0][7:0]), .mask(mask_a[0][7:0]),
        .clr(clr_a[0]), .idx(idx0), .valid(valid0), .ready(ready_a[0]),
        .pending(pend0), .drop(drop0));

    req_encoder_queue #(.N(8), .RR(1)) dut_rr8 (
        .clk(clk), .rst_n(rst_n), .req(req_a[1][7:0]), .mask(mask_a[1][7:0]),
        .clr(clr_a[1]), .idx(idx1), .valid(valid1), .ready(ready_a[1]),
        .pending(pend1), .drop(drop1));

    req_encoder_queue #(.N(5), .RR(1)) dut_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req_a[2][4:0]), .mask(mask_a[2][4:0]),
        .clr(clr_a[2]), .idx(idx2), .valid(valid2), .ready(ready_a[2]),
        .pending(pend2), .drop(drop2));

    assign a_valid[0] = valid0;  assign a_idx[0] = 6'(idx0);
    assign a_valid[1] = valid1;  assign a_idx[1] = 6'(idx1);
    assign a_valid[2] = valid2;  assign a_idx[2] = 6'(idx2);
    assign a_pend[0]  = 64'(pend0);
    assign a_pend[1]  = 64'(pend1);
    assign a_pend[2]  = 64'(pend2);
    assign a_drop[0]  = drop0;  assign a_drop[1] = drop1;  assign a_drop[2] = drop2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] pend;
        logic        valid;
        logic [5:0]  idx;
        logic        drop;
        logic [5:0]  ptr;
    } mst_t;

    mst_t m[3];

    function automatic int n_of(int d);
        return (d == 2) ? 5 : 8;
    endfunction

    function automatic mst_t step(mst_t s, logic [63:0] rq, logic [63:0] mk,
                                  logic cl, logic rdy, int n, bit rr);
        mst_t        t;
        logic [63:0] all;
        logic [63:0] taken;
        int          sel;
        int          k;
        t     = s;
        all   = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        taken = '0;
        sel   = -1;
        rq    = rq & all;
        if (!s.valid || rdy) begin
            // Scan n positions; round-robin starts at ptr and wraps modulo n.
            for (int j = 0; j < n; j++) begin
                k = rr ? ((int'(s.ptr) + j) % n) : j;
                if (sel < 0 && s.pend[k] && mk[k]) sel = k;
            end
            if (sel >= 0) begin
                t.valid    = 1'b1;
                t.idx      = 6'(sel);
                taken[sel] = 1'b1;
                if (rr) t.ptr = 6'((sel + 1) % n);
            end else begin
                t.valid = 1'b0;
            end
        end
        t.drop = |(rq & s.pend & ~taken);
        t.pend = (s.pend & ~taken) | rq;
        if (cl) begin
            t.pend  = '0;
            t.valid = 1'b0;
            t.ptr   = '0;
            t.drop  = 1'b0;
        end
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) m[d] <= '0;
        end else begin
            for (int d = 0; d < 3; d++)
                m[d] <= step(m[d], req_a[d], mask_a[d], clr_a[d], ready_a[d],
                             n_of(d), d != 0);
        end
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && !done) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d.valid", d), 64'(a_valid[d]), 64'(m[d].valid));
                chk($sformatf("d%0d.pending", d), a_pend[d], m[d].pend);
                chk($sformatf("d%0d.drop", d), 64'(a_drop[d]), 64'(m[d].drop));
                if (m[d].valid)
                    chk($sformatf("d%0d.idx", d), 64'(a_idx[d]), 64'(m[d].idx));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(string nm, logic v, logic [5:0] i, logic [63:0] p, logic dr);
        chk({nm, ".valid"}, 64'(a_valid[0]), 64'(v));
        if (v) chk({nm, ".idx"}, 64'(a_idx[0]), 64'(i));
        chk({nm, ".pending"}, a_pend[0], p);
        chk({nm, ".drop"}, 64'(a_drop[0]), 64'(dr));
    endtask

    initial begin
        int e;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_a[d]   = '0;
            mask_a[d]  = '1;
            clr_a[d]   = 1'b0;
            ready_a[d] = 1'b1;
        end
        #1;
        chk0("reset", 1'b0, 6'd0, 64'h0, 1'b0);
        chk("reset.idx", 64'(a_idx[0]), 64'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fixed priority burst.
        req_a[0] = 64'h94; cyc(); req_a[0] = 0;
        chk0("fp.pend", 1'b0, 6'd0, 64'h94, 1'b0);
        cyc(); chk0("fp.i2", 1'b1, 6'd2, 64'h90, 1'b0);
        cyc(); chk0("fp.i4", 1'b1, 6'd4, 64'h80, 1'b0);
        cyc(); chk0("fp.i7", 1'b1, 6'd7, 64'h00, 1'b0);
        cyc(); chk0("fp.idle", 1'b0, 6'd0, 64'h00, 1'b0);

        // Backpressure.
        ready_a[0] = 0;
        req_a[0] = 64'h01; cyc();
        req_a[0] = 64'h80; cyc(); req_a[0] = 0;
        chk0("bp.load", 1'b1, 6'd0, 64'h80, 1'b0);
        cyc(); chk0("bp.hold", 1'b1, 6'd0, 64'h80, 1'b0);
        ready_a[0] = 1;
        cyc(); chk0("bp.i7", 1'b1, 6'd7, 64'h00, 1'b0);
        cyc(); chk0("bp.idle", 1'b0, 6'd0, 64'h00, 1'b0);

        // Collision while stalled: one drop, bit 3 served once.
        ready_a[0] = 0;
        req_a[0] = 64'h01; cyc();
        req_a[0] = 0; cyc();
        req_a[0] = 64'h08; cyc();
        req_a[0] = 64'h08; cyc(); chk0("drop.pulse", 1'b1, 6'd0, 64'h08, 1'b1);
        req_a[0] = 0; cyc(); chk0("drop.end", 1'b1, 6'd0, 64'h08, 1'b0);
        ready_a[0] = 1;
        cyc(); chk0("drop.i3", 1'b1, 6'd3, 64'h00, 1'b0);
        cyc(); chk0("drop.idle", 1'b0, 6'd0, 64'h00, 1'b0);
        // Re-request on the bit being loaded: no drop, served twice.
        ready_a[0] = 0;
        req_a[0] = 64'h08; cyc();
        ready_a[0] = 1; cyc(); chk0("repend.a", 1'b1, 6'd3, 64'h08, 1'b0);
        req_a[0] = 0; cyc(); chk0("repend.b", 1'b1, 6'd3, 64'h00, 1'b0);
        cyc(); chk0("repend.idle", 1'b0, 6'd0, 64'h00, 1'b0);

        // Mask and clear.
        mask_a[0] = 64'hF0; req_a[0] = 64'h11; cyc(); req_a[0] = 0;
        cyc(); chk0("mask.i4", 1'b1, 6'd4, 64'h01, 1'b0);
        cyc(); chk0("mask.keep", 1'b0, 6'd0, 64'h01, 1'b0);
        mask_a[0] = 64'hFF;
        cyc(); chk0("mask.i0", 1'b1, 6'd0, 64'h00, 1'b0);
        cyc();
        req_a[0] = 64'h02; cyc();
        clr_a[0] = 1; cyc(); chk0("clr", 1'b0, 6'd0, 64'h00, 1'b0);
        clr_a[0] = 0; req_a[0] = 0;
        cyc(); chk0("clr.after", 1'b0, 6'd0, 64'h00, 1'b0);

        // Asynchronous reset with valid=1 and pending=A5.
        ready_a[0] = 0;
        req_a[0] = 64'hA5; cyc();
        req_a[0] = 64'h01; cyc(); req_a[0] = 0;
        chk0("pre_rst", 1'b1, 6'd0, 64'hA5, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk0("async_rst", 1'b0, 6'd0, 64'h00, 1'b0);
        chk("async_rst.idx", 64'(a_idx[0]), 64'h0);
        cyc(); rst_n = 1'b1; ready_a[0] = 1;
        cyc(); cyc(); chk0("rst.idle", 1'b0, 6'd0, 64'h00, 1'b0);

        // Round-robin with every bit continuously requested.
        req_a[1] = 64'hFF; req_a[2] = 64'h1F;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k >= 2) begin
                e = k - 2;
                chk("rr8.valid", 64'(a_valid[1]), 64'h1);
                chk("rr8.idx", 64'(a_idx[1]), 64'(e % 8));
                chk("rr5.valid", 64'(a_valid[2]), 64'h1);
                chk("rr5.idx", 64'(a_idx[2]), 64'(e % 5));
            end
        end
        req_a[1] = 0; req_a[2] = 0;
        for (int k = 0; k < 10; k++) cyc();

        // Randomized traffic on all three instances.
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                req_a[d]   = {$urandom, $urandom} & {$urandom, $urandom}
                             & ((64'd1 << n_of(d)) - 64'd1);
                mask_a[d]  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
                ready_a[d] = ($urandom_range(0, 3) != 0);
                clr_a[d]   = ($urandom_range(0, 99) == 0);
            end
            cyc();
        end

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
